// File: rtl/fpalu_seq_ctrl_pkg.sv
// Shared definitions for the FPALU issue/response controller: FP opcode
// encodings, default per-op latencies, FSM state type and latency helpers.
package fpalu_seq_ctrl_pkg;

  // FP opcode encodings as seen on the 5-bit FPALU opcode bus
  localparam logic [4:0] FOPADD    = 5'd0;
  localparam logic [4:0] FOPSUB    = 5'd1;
  localparam logic [4:0] FOPMUL    = 5'd2;
  localparam logic [4:0] FOPDIV    = 5'd3;
  localparam logic [4:0] FOPSQRT   = 5'd4;
  localparam logic [4:0] FOPABS    = 5'd5;
  localparam logic [4:0] FOPNEG    = 5'd6;
  localparam logic [4:0] FOPSGNJ   = 5'd7;
  localparam logic [4:0] FOPSGNJN  = 5'd8;
  localparam logic [4:0] FOPSGNJX  = 5'd9;
  localparam logic [4:0] FOPCEQ    = 5'd10;
  localparam logic [4:0] FOPCLT    = 5'd11;
  localparam logic [4:0] FOPCLE    = 5'd12;
  localparam logic [4:0] FOPMAX    = 5'd13;
  localparam logic [4:0] FOPMIN    = 5'd14;
  localparam logic [4:0] FOPCVTSW  = 5'd15;
  localparam logic [4:0] FOPCVTWS  = 5'd16;
  localparam logic [4:0] FOPCVTSWU = 5'd17;
  localparam logic [4:0] FOPCVTWUS = 5'd18;

  // Default latencies (in cycles) of the underlying FP cores
  localparam int DEF_LAT_ADD  = 7;
  localparam int DEF_LAT_MUL  = 5;
  localparam int DEF_LAT_DIV  = 6;
  localparam int DEF_LAT_SQRT = 16;
  localparam int DEF_LAT_CVT  = 6;
  localparam int DEF_LAT_CMP  = 1;
  localparam int DEF_LAT_MISC = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // A configured latency of 0 still needs one cycle in RUN
  function automatic int norm_lat(input int lat);
    return (lat < 1) ? 1 : lat;
  endfunction

  // Largest effective latency, used to size the countdown counter
  function automatic int max_lat(input int a, input int b, input int c,
                                 input int d, input int e, input int f,
                                 input int g);
    int m;
    m = norm_lat(a);
    if (norm_lat(b) > m) m = norm_lat(b);
    if (norm_lat(c) > m) m = norm_lat(c);
    if (norm_lat(d) > m) m = norm_lat(d);
    if (norm_lat(e) > m) m = norm_lat(e);
    if (norm_lat(f) > m) m = norm_lat(f);
    if (norm_lat(g) > m) m = norm_lat(g);
    return m;
  endfunction

endpackage

// File: rtl/fpalu_lat_lut.sv
// Combinational opcode-to-latency decode for the FPALU sequencer.
// Undefined opcodes fall into the single-cycle misc class.
module fpalu_lat_lut
  import fpalu_seq_ctrl_pkg::*;
#(
  parameter int LAT_ADD  = DEF_LAT_ADD,
  parameter int LAT_MUL  = DEF_LAT_MUL,
  parameter int LAT_DIV  = DEF_LAT_DIV,
  parameter int LAT_SQRT = DEF_LAT_SQRT,
  parameter int LAT_CVT  = DEF_LAT_CVT,
  parameter int LAT_CMP  = DEF_LAT_CMP,
  parameter int LAT_MISC = DEF_LAT_MISC,
  parameter int CNT_W    = 5
) (
  input  logic [4:0]       op,
  output logic [CNT_W-1:0] lat
);

  // Select the effective (never zero) latency of the requested op class
  always_comb begin
    lat = CNT_W'(norm_lat(LAT_MISC));
    case (op)
      FOPADD, FOPSUB:                          lat = CNT_W'(norm_lat(LAT_ADD));
      FOPMUL:                                  lat = CNT_W'(norm_lat(LAT_MUL));
      FOPDIV:                                  lat = CNT_W'(norm_lat(LAT_DIV));
      FOPSQRT:                                 lat = CNT_W'(norm_lat(LAT_SQRT));
      FOPCVTSW, FOPCVTWS, FOPCVTSWU, FOPCVTWUS: lat = CNT_W'(norm_lat(LAT_CVT));
      FOPCEQ, FOPCLT, FOPCLE, FOPMAX, FOPMIN:   lat = CNT_W'(norm_lat(LAT_CMP));
      default:                                 lat = CNT_W'(norm_lat(LAT_MISC));
    endcase
  end

endmodule

// File: rtl/fpalu_seq_ctrl.sv
// Initiator-side issue/response controller for the FPALU. Holds operands
// and opcode stable for the op's latency, captures result and flags, then
// pulses odone. obusy stalls the CPU pipeline while an op is in flight.
// Optional sticky IEEE flag register enabled by FPSEQ_STICKY_FLAGS_EN.
module fpalu_seq_ctrl
  import fpalu_seq_ctrl_pkg::*;
#(
  parameter int LAT_ADD  = DEF_LAT_ADD,
  parameter int LAT_MUL  = DEF_LAT_MUL,
  parameter int LAT_DIV  = DEF_LAT_DIV,
  parameter int LAT_SQRT = DEF_LAT_SQRT,
  parameter int LAT_CVT  = DEF_LAT_CVT,
  parameter int LAT_CMP  = DEF_LAT_CMP,
  parameter int LAT_MISC = DEF_LAT_MISC
) (
  input  logic        iclock,
  input  logic        ireset,
  input  logic        istart,
  input  logic [4:0]  iop,
  input  logic [31:0] idataa,
  input  logic [31:0] idatab,
  output logic        obusy,
  output logic        odone,
  output logic [31:0] oresult,
  output logic        onan,
  output logic        ozero,
  output logic        ooverflow,
  output logic        ounderflow,
  output logic        oCompResult,
  output logic [31:0] ofpa,
  output logic [31:0] ofpb,
  output logic [4:0]  ofpop,
  input  logic [31:0] ifpresult,
  input  logic        ifpnan,
  input  logic        ifpzero,
  input  logic        ifpoverflow,
  input  logic        ifpunderflow,
  input  logic        ifpcomp
`ifdef FPSEQ_STICKY_FLAGS_EN
  ,
  input  logic        iflagclr,
  output logic [4:0]  oflags
`endif
);

  localparam int MAX_LAT = max_lat(LAT_ADD, LAT_MUL, LAT_DIV, LAT_SQRT,
                                   LAT_CVT, LAT_CMP, LAT_MISC);
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  seq_state_t       state;
  seq_state_t       next_state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] lat;
  logic             accept;
  logic             capture;

  fpalu_lat_lut #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT),
    .LAT_CVT  (LAT_CVT),
    .LAT_CMP  (LAT_CMP),
    .LAT_MISC (LAT_MISC),
    .CNT_W    (CNT_W)
  ) u_lat_lut (
    .op  (iop),
    .lat (lat)
  );

  // A new op may be issued from IDLE or straight out of DONE (no bubble)
  assign accept  = istart && ((state == IDLE) || (state == DONE));
  assign capture = (state == RUN) && (count == '0);

  // State register
  always_ff @(posedge iclock) begin
    if (ireset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; requests arriving during RUN are simply ignored
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (istart) next_state = RUN;
      RUN:     if (count == '0) next_state = DONE;
      DONE:    next_state = istart ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    obusy = (state == RUN);
    odone = (state == DONE);
  end

  // Latch operands on issue and count down the op latency
  always_ff @(posedge iclock) begin
    if (ireset) begin
      count <= '0;
      ofpa  <= '0;
      ofpb  <= '0;
      ofpop <= '0;
    end else if (accept) begin
      count <= lat - CNT_W'(1);
      ofpa  <= idataa;
      ofpb  <= idatab;
      ofpop <= iop;
    end else if ((state == RUN) && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Capture the FPALU result and flags at the end of the last RUN cycle
  always_ff @(posedge iclock) begin
    if (ireset) begin
      oresult     <= '0;
      onan        <= 1'b0;
      ozero       <= 1'b0;
      ooverflow   <= 1'b0;
      ounderflow  <= 1'b0;
      oCompResult <= 1'b0;
    end else if (capture) begin
      oresult     <= ifpresult;
      onan        <= ifpnan;
      ozero       <= ifpzero;
      ooverflow   <= ifpoverflow;
      ounderflow  <= ifpunderflow;
      oCompResult <= ifpcomp;
    end
  end

`ifdef FPSEQ_STICKY_FLAGS_EN
  logic [4:0] new_flags;
  logic       div_by_zero;

  // Divide-by-zero is inferred from the held operands; NX is never raised
  always_comb begin
    div_by_zero = (ofpop == FOPDIV) && (ofpb[30:0] == 31'd0) && !ifpnan;
    new_flags   = {ifpnan, div_by_zero, ifpoverflow, ifpunderflow, 1'b0};
  end

  // Sticky accumulation; a simultaneous clear drops old flags but keeps new ones
  always_ff @(posedge iclock) begin
    if (ireset) begin
      oflags <= '0;
    end else if (iflagclr || capture) begin
      oflags <= (iflagclr ? 5'b0 : oflags) | (capture ? new_flags : 5'b0);
    end
  end
`endif

endmodule

// File: tb/tb_fpalu_seq_ctrl.sv
// Directed testbench for fpalu_seq_ctrl with a behavioural FPALU model
// whose results only become valid after the op's latency has elapsed.
// Sticky flag checks are compiled in with FPSEQ_STICKY_FLAGS_EN.
module tb_fpalu_seq_ctrl;
  import fpalu_seq_ctrl_pkg::*;

  logic        iclock;
  logic        ireset;
  logic        istart;
  logic [4:0]  iop;
  logic [31:0] idataa;
  logic [31:0] idatab;
  logic        obusy;
  logic        odone;
  logic [31:0] oresult;
  logic        onan;
  logic        ozero;
  logic        ooverflow;
  logic        ounderflow;
  logic        oCompResult;
  logic [31:0] ofpa;
  logic [31:0] ofpb;
  logic [4:0]  ofpop;
  logic [31:0] ifpresult;
  logic        ifpnan;
  logic        ifpzero;
  logic        ifpoverflow;
  logic        ifpunderflow;
  logic        ifpcomp;
`ifdef FPSEQ_STICKY_FLAGS_EN
  logic        iflagclr;
  logic [4:0]  oflags;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;

  fpalu_seq_ctrl dut (
    .iclock       (iclock),
    .ireset       (ireset),
    .istart       (istart),
    .iop          (iop),
    .idataa       (idataa),
    .idatab       (idatab),
    .obusy        (obusy),
    .odone        (odone),
    .oresult      (oresult),
    .onan         (onan),
    .ozero        (ozero),
    .ooverflow    (ooverflow),
    .ounderflow   (ounderflow),
    .oCompResult  (oCompResult),
    .ofpa         (ofpa),
    .ofpb         (ofpb),
    .ofpop        (ofpop),
    .ifpresult    (ifpresult),
    .ifpnan       (ifpnan),
    .ifpzero      (ifpzero),
    .ifpoverflow  (ifpoverflow),
    .ifpunderflow (ifpunderflow),
    .ifpcomp      (ifpcomp)
`ifdef FPSEQ_STICKY_FLAGS_EN
    ,
    .iflagclr     (iflagclr),
    .oflags       (oflags)
`endif
  );

  // Free-running clock
  initial begin
    iclock = 1'b0;
    forever #5 iclock = ~iclock;
  end

  // Count rising edges so absolute cycle positions can be checked
  always @(posedge iclock) cycleCount <= cycleCount + 1;

  // Per-op core latency of the modelled FPALU
  function automatic int modelLat(input logic [4:0] op);
    case (op)
      FOPADD, FOPSUB:                           return DEF_LAT_ADD;
      FOPMUL:                                   return DEF_LAT_MUL;
      FOPDIV:                                   return DEF_LAT_DIV;
      FOPSQRT:                                  return DEF_LAT_SQRT;
      FOPCVTSW, FOPCVTWS, FOPCVTSWU, FOPCVTWUS: return DEF_LAT_CVT;
      FOPCEQ, FOPCLT, FOPCLE, FOPMAX, FOPMIN:   return DEF_LAT_CMP;
      default:                                  return DEF_LAT_MISC;
    endcase
  endfunction

  // Known answers for the vectors used here: {comp,nan,zero,of,uf,result}
  function automatic logic [36:0] fpModel(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [36:0] r;
    r = '0;
    case (op)
      FOPADD:  if (a == 32'h3F800000 && b == 32'h40000000) r[31:0] = 32'h40400000;
      FOPMUL:  if (a == 32'h40000000 && b == 32'h40400000) r[31:0] = 32'h40C00000;
      FOPDIV: begin
        if (b[30:0] == 31'd0)        r[31:0] = 32'h7F800000;
        else if (b == 32'h3F800000)  r[31:0] = a;
      end
      FOPSQRT: begin
        if (a == 32'h41800000)       r[31:0] = 32'h40800000;
        else if (a[31]) begin
          r[31:0] = 32'h7FC00000;
          r[35]   = 1'b1;
        end
      end
      FOPABS: begin
        r[31:0] = {1'b0, a[30:0]};
        r[34]   = (a[30:0] == 31'd0);
      end
      FOPCLT:  r[36] = (a == 32'hBF800000 && b == 32'h3F800000);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Behavioural FPALU: garbage until the operands have been stable for L cycles
  logic [68:0] prevOps = '0;
  int          opAge   = 0;
  always @(negedge iclock) begin
    logic [36:0] r;
    if ({ofpop, ofpa, ofpb} != prevOps) opAge = 1;
    else if (opAge < 1000)              opAge = opAge + 1;
    prevOps = {ofpop, ofpa, ofpb};
    if (opAge >= modelLat(ofpop)) r = fpModel(ofpop, ofpa, ofpb);
    else                          r = {5'b11111, 32'hDEADBEEF};
    {ifpcomp, ifpnan, ifpzero, ifpoverflow, ifpunderflow, ifpresult} = r;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [4:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    istart = start;
    iop    = op;
    idataa = a;
    idatab = b;
  endtask

  // Issue one op and follow it through RUN into DONE, checking along the way
  task automatic runOp(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] expResult,
                       input logic expComp, input logic [3:0] expFlags,
                       input logic releaseStart);
    applyStimulus(1'b1, op, a, b);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge iclock);
      if (k <= lat) begin
        checkOutput({tag, " busy"}, {31'd0, obusy}, 32'd1);
        checkOutput({tag, " nodone"}, {31'd0, odone}, 32'd0);
        checkOutput({tag, " ofpa"}, ofpa, a);
      end else begin
        checkOutput({tag, " done"}, {31'd0, odone}, 32'd1);
        checkOutput({tag, " idle"}, {31'd0, obusy}, 32'd0);
        checkOutput({tag, " result"}, oresult, expResult);
        checkOutput({tag, " comp"}, {31'd0, oCompResult}, {31'd0, expComp});
        checkOutput({tag, " flags"}, {28'd0, onan, ozero, ooverflow, ounderflow},
                    {28'd0, expFlags});
        if (releaseStart) istart = 1'b0;
      end
    end
  endtask

  initial begin
    int startCycle;
    ireset = 1'b1;
    applyStimulus(1'b0, FOPADD, 32'd0, 32'd0);
`ifdef FPSEQ_STICKY_FLAGS_EN
    iflagclr = 1'b0;
`endif
    repeat (3) @(negedge iclock);
    ireset = 1'b0;
    checkOutput("rst busy", {31'd0, obusy}, 32'd0);
    checkOutput("rst done", {31'd0, odone}, 32'd0);
    checkOutput("rst result", oresult, 32'd0);
    checkOutput("rst ofpa", ofpa, 32'd0);
    checkOutput("rst ofpop", {27'd0, ofpop}, 32'd0);
    checkOutput("rst comp", {31'd0, oCompResult}, 32'd0);
`ifdef FPSEQ_STICKY_FLAGS_EN
    checkOutput("rst oflags", {27'd0, oflags}, 32'd0);
`endif
    @(negedge iclock);

    $display("[TB] add 1.0 + 2.0");
    runOp("add", FOPADD, 32'h3F800000, 32'h40000000, 7, 32'h40400000, 1'b0, 4'b0000, 1'b1);
    @(negedge iclock);
    checkOutput("add back idle", {31'd0, odone}, 32'd0);
    checkOutput("add hold", oresult, 32'h40400000);

    $display("[TB] back-to-back mul then sqrt");
    startCycle = cycleCount;
    runOp("mul", FOPMUL, 32'h40000000, 32'h40400000, 5, 32'h40C00000, 1'b0, 4'b0000, 1'b0);
    checkOutput("mul done cycle", cycleCount - startCycle, 32'd6);
    runOp("sqrt", FOPSQRT, 32'h41800000, 32'h00000000, 16, 32'h40800000, 1'b0, 4'b0000, 1'b1);
    checkOutput("sqrt done cycle", cycleCount - startCycle, 32'd23);
    @(negedge iclock);

    $display("[TB] compare and single-cycle misc");
    runOp("clt", FOPCLT, 32'hBF800000, 32'h3F800000, 1, 32'h00000000, 1'b1, 4'b0000, 1'b1);
    @(negedge iclock);
    runOp("abs", FOPABS, 32'h80000000, 32'h00000000, 1, 32'h00000000, 1'b0, 4'b0100, 1'b1);
    checkOutput("abs comp cleared", {31'd0, oCompResult}, 32'd0);
    @(negedge iclock);
    runOp("sqrt2", FOPSQRT, 32'h41800000, 32'h00000000, 16, 32'h40800000, 1'b0, 4'b0000, 1'b1);

    $display("[TB] reset in the middle of a divide");
    applyStimulus(1'b1, FOPDIV, 32'h40000000, 32'h3F800000);
    repeat (3) @(negedge iclock);
    ireset = 1'b1;
    istart = 1'b0;
    @(negedge iclock);
    ireset = 1'b0;
    checkOutput("mid rst busy", {31'd0, obusy}, 32'd0);
    checkOutput("mid rst done", {31'd0, odone}, 32'd0);
    checkOutput("mid rst result", oresult, 32'd0);
    checkOutput("mid rst ofpa", ofpa, 32'd0);
    checkOutput("mid rst ofpb", ofpb, 32'd0);
    checkOutput("mid rst ofpop", {27'd0, ofpop}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge iclock);
      checkOutput("mid rst no done", {31'd0, odone}, 32'd0);
    end
    runOp("add after rst", FOPADD, 32'h3F800000, 32'h40000000, 7, 32'h40400000, 1'b0, 4'b0000, 1'b1);
    @(negedge iclock);

    $display("[TB] request changes while busy are ignored");
    applyStimulus(1'b1, FOPADD, 32'h3F800000, 32'h40000000);
    for (int k = 1; k <= 7; k++) begin
      @(negedge iclock);
      if (k == 2) applyStimulus(1'b1, FOPMUL, 32'h40000000, 32'h40400000);
      checkOutput("ign ofpa", ofpa, 32'h3F800000);
      checkOutput("ign ofpop", {27'd0, ofpop}, {27'd0, FOPADD});
    end
    @(negedge iclock);
    checkOutput("ign done", {31'd0, odone}, 32'd1);
    checkOutput("ign result", oresult, 32'h40400000);
    runOp("ign next", FOPMUL, 32'h40000000, 32'h40400000, 5, 32'h40C00000, 1'b0, 4'b0000, 1'b1);
    @(negedge iclock);

`ifdef FPSEQ_STICKY_FLAGS_EN
    $display("[TB] sticky flags");
    runOp("div0", FOPDIV, 32'h3F800000, 32'h00000000, 6, 32'h7F800000, 1'b0, 4'b0000, 1'b1);
    checkOutput("div0 oflags", {27'd0, oflags}, 32'b01000);
    @(negedge iclock);
    runOp("sqrtneg", FOPSQRT, 32'hBF800000, 32'h00000000, 16, 32'h7FC00000, 1'b0, 4'b1000, 1'b1);
    checkOutput("sqrtneg oflags", {27'd0, oflags}, 32'b11000);
    iflagclr = 1'b1;
    @(negedge iclock);
    iflagclr = 1'b0;
    checkOutput("clr oflags", {27'd0, oflags}, 32'd0);
    runOp("div0 again", FOPDIV, 32'h3F800000, 32'h00000000, 6, 32'h7F800000, 1'b0, 4'b0000, 1'b1);
    @(negedge iclock);
    applyStimulus(1'b1, FOPSQRT, 32'hBF800000, 32'h00000000);
    repeat (16) @(negedge iclock);
    iflagclr = 1'b1;
    @(negedge iclock);
    iflagclr = 1'b0;
    istart   = 1'b0;
    checkOutput("clr+cap done", {31'd0, odone}, 32'd1);
    checkOutput("clr+cap oflags", {27'd0, oflags}, 32'b10000);
    @(negedge iclock);
`endif

    $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fpalu_seq_ctrl.md
Name: fpalu_seq_ctrl

Overview:
- Issue/response controller on the initiator side of the FPALU interface.
- Accepts one FP operation from the CPU control path and holds operands and opcode stable on the FPALU inputs for the per-op latency of the underlying FP cores.
- Captures the FPALU result, flags and compare bit, then pulses done.
- Drives the stall signal that freezes the pipeline while a multi-cycle FP op is in flight.

Parameters:
- LAT_ADD, 7, cycles for FOPADD/FOPSUB.
- LAT_MUL, 5, cycles for FOPMUL.
- LAT_DIV, 6, cycles for FOPDIV.
- LAT_SQRT, 16, cycles for FOPSQRT.
- LAT_CVT, 6, cycles for FOPCVTSW/FOPCVTWS/FOPCVTSWU/FOPCVTWUS.
- LAT_CMP, 1, cycles for FOPCEQ/FOPCLT/FOPCLE/FOPMAX/FOPMIN.
- LAT_MISC, 1, cycles for ABS/NEG/SGNJ/SGNJN/SGNJX and any undefined opcode.

Ports:
- iclock  in  1  system clock
- ireset  in  1  synchronous, active-high reset
- istart  in  1  request to issue an op (level, sampled each cycle)
- iop  in  5  FOP* opcode
- idataa  in  32  operand A
- idatab  in  32  operand B
- obusy  out  1  op in flight; pipeline stall
- odone  out  1  one-cycle pulse, result valid
- oresult  out  32  captured result
- onan, ozero, ooverflow, ounderflow  out  1 each  captured flags
- oCompResult  out  1  captured compare bit
- ofpa, ofpb  out  32 each  operands to FPALU (registered)
- ofpop  out  5  opcode to FPALU (registered)
- ifpresult  in  32  FPALU result
- ifpnan, ifpzero, ifpoverflow, ifpunderflow  in  1 each  FPALU flags
- ifpcomp  in  1  FPALU compare bit
- iflagclr  in  1  clear sticky flags (only with FPSEQ_STICKY_FLAGS_EN)
- oflags  out  5  sticky {NV,DZ,OF,UF,NX} (only with FPSEQ_STICKY_FLAGS_EN)

Behaviour:
- Reset:
  - Clock iclock; reset ireset is synchronous and active-high.
  - On a reset edge: state=IDLE, counter=0; every output register (oresult, ofpa, ofpb, ofpop, flags, oCompResult, oflags) is 0; obusy=0, odone=0.
  - Reset asserted mid-op discards the op. No odone is produced and the captured registers are not updated.
- States:
  - IDLE: obusy=0, odone=0.
  - RUN: obusy=1.
  - DONE: odone=1, obusy=0.
- Transitions:
  - IDLE with istart=1: on the edge, latch idataa/idatab/iop into ofpa/ofpb/ofpop, load counter=L(iop)-1, go to RUN.
  - RUN with counter!=0: decrement counter.
  - RUN with counter==0: on the edge, capture ifpresult, ifp* flags and ifpcomp into the output registers, go to DONE.
  - DONE with istart=1: behave as IDLE with istart=1 (back-to-back issue, no bubble).
  - DONE with istart=0: go to IDLE.
- Timing: if start is accepted at edge of cycle 0, RUN occupies cycles 1..L, capture happens at the end of cycle L, and DONE/odone occurs in cycle L+1. L=1 gives odone two cycles after the start request.
- Ignored requests: istart while in RUN is ignored (no queue). The CPU keeps the request asserted while obusy=1.
- Operand stability: ofpa/ofpb/ofpop stay constant from issue until the next accepted start. This holds for the whole latency window of the pipelined cores.
- Result hold: oresult, flags and oCompResult hold their captured values until the next capture.
- Latency function: L(op) is selected from the parameters. A parameter value of 0 is treated as 1.
- Counter width: $clog2(max latency)+1 bits.

Optional Feature:
- Macro: FPSEQ_STICKY_FLAGS_EN.
- Defined:
  - oflags register accumulates flags on each capture: NV|=ifpnan, OF|=ifpoverflow, UF|=ifpunderflow.
  - DZ |= (ofpop==FOPDIV && ofpb[30:0]==0 && !ifpnan).
  - NX is held 0.
  - iflagclr zeroes oflags. If clear and capture occur on the same edge, the clear wins and the new flags are then ORed in (the capture's flags survive).
- Undefined: iflagclr and oflags are absent; no extra state.

Decomposition:
- FOP* opcode constants stay in the shared Parametros include; the default latency values are added there as named constants.
- Sub-module fpalu_lat_lut: combinational op→latency decode, parameterised with the LAT_* values.
- FSM, counter and capture registers live in fpalu_seq_ctrl.
- Bench uses a behavioural FPALU model whose per-op delay is set from the same constants.

Test Plan:
- Add: reset, then istart with FOPADD, a=0x3F800000, b=0x40000000 → obusy high cycles 1..7, odone in cycle 8, oresult=0x40400000, ozero=0.
- Back-to-back: FOPMUL 2.0×3.0 issued, istart held into DONE with FOPSQRT a=0x41800000 → first oresult=0x40C00000 (odone cycle 6), second issue at cycle 6 with no idle cycle, oresult=0x40800000 (odone cycle 23).
- Compare: FOPCLT a=0xBF800000, b=0x3F800000 → odone cycle 2, oCompResult=1, oresult=0.
- Reset mid-op: ireset asserted in cycle 3 of FOPDIV → no odone, all outputs 0 next cycle, a new FOPADD then completes normally.
- Ignored request: change iop/idataa while obusy=1 → ofpa/ofpop unchanged until DONE.
- Sticky flags (FPSEQ_STICKY_FLAGS_EN): FOPDIV 1.0/0.0 → oflags=5'b01000; then FOPSQRT of -1.0 → oflags=5'b11000; iflagclr → oflags=0.
